alu_res_buf: RTL and testbench
==============================

ALU_RES_BUF -- requirements
Module: alu_res_buf

Interface
REQ-001 The module SHALL have parameter DATA_W, default 4, meaning result width from the adder/subtractor stage.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, at least 2).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid  input  1  upstream adder result valid.
REQ-006 The module SHALL have port in_ready  output  1  buffer accepts a result this cycle.
REQ-007 The module SHALL have port s  input  DATA_W  adder sum/difference.
REQ-008 The module SHALL have ports overflow, zero, out_c  input  1 each  adder flags as produced upstream.
REQ-009 The module SHALL have port out_valid  output  1  head entry valid.
REQ-010 The module SHALL have port out_ready  input  1  downstream consumes head.
REQ-011 The module SHALL have port out_s  output  DATA_W  head result.
REQ-012 The module SHALL have port out_flags  output  3  head flags {overflow, out_c, zero}.
REQ-013 The module SHALL have port flag_err  output  1  sticky: some accepted entry had zero != (s==0).
REQ-014 The module SHALL have port clr  input  1  clears sticky state (flag_err, plus REQ-030 state); buffer untouched.

Function
REQ-015 Push SHALL occur exactly when in_valid && in_ready; pop exactly when out_valid && out_ready.
REQ-016 in_ready SHALL equal !full, combinationally from registered count only (no dependence on out_ready).
REQ-017 out_valid SHALL equal !empty; out_s/out_flags SHALL show the head entry combinationally (first-word fall-through).
REQ-018 A pushed entry SHALL be visible on outputs the cycle after the push edge (1-cycle latency when empty).
REQ-019 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Occupancy count SHALL be log2(DEPTH)+1 bits; simultaneous push and pop SHALL leave count unchanged.
REQ-021 When full, in_valid SHALL be ignored even if out_ready is high that cycle.
REQ-022 When empty, out_ready SHALL be ignored; pointers and count unchanged.
REQ-023 Out_s/out_flags while empty SHALL be don't-care but are driven to zero.
REQ-024 flag_err SHALL set on the edge after a push whose zero disagrees with (s==0) and hold until clr or rst.
REQ-025 clr and a set condition in the same cycle SHALL result in flag_err = 1 (set wins).

Reset
REQ-026 On rst high at a clock edge: pointers and count 0, out_valid 0, in_ready 1 the following cycle, flag_err 0, all REQ-030 state 0.
REQ-027 rst SHALL override push, pop and clr in the same cycle; entries in flight are discarded.
REQ-028 Storage array contents SHALL NOT require reset.

Configuration
REQ-029 Macro ALU_RES_BUF_STATS_EN SHALL control the statistics feature.
REQ-030 With ALU_RES_BUF_STATS_EN defined: output of_cnt (8 bits, saturating at 255) SHALL count pushes with overflow=1, and output c_cnt (8 bits, saturating) pushes with out_c=1; both cleared by clr (clr wins over increment) and rst.
REQ-031 Without the macro: of_cnt and c_cnt ports SHALL be absent; all other behaviour identical.

Structure
REQ-032 A shared package alu_pkg SHALL hold the flag-bundle typedef {overflow, out_c, zero}, its bit-index constants, and the counter width constant (8).
REQ-033 Storage and pointer logic SHALL be one sub-module, res_fifo (parameterised width and depth, push/pop/full/empty); stats and flag_err logic stay in the top.

Verification
REQ-034 Reset then push s=4'h5 flags {0,0,0} -> next cycle out_valid=1, out_s=5, out_flags=3'b000, in_ready=1.
REQ-035 Push 4 results (7+1=8 overflow, -8+-8=0 of/c/zero, 3, 2) with out_ready=0 -> in_ready=0 after 4th; 5th push ignored; drain yields 8/3'b100, 0/3'b111, 3, 2 in order.
REQ-036 Full buffer, in_valid=1 and out_ready=1 same cycle -> one pop, no push, count=3.
REQ-037 Half-full, simultaneous push and pop for 10 cycles -> count constant 2, pointer wrap, order preserved.
REQ-038 Push s=4'h0 with zero=0 -> flag_err=1 next cycle; clr -> 0; clr concurrent with bad push -> stays 1.
REQ-039 With ALU_RES_BUF_STATS_EN, 300 overflow pushes -> of_cnt=255 saturated; rst mid-stream -> all outputs per REQ-026 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result buffer: flag bundle layout and the stats counter width.
package alu_pkg;

  typedef struct packed {
    logic overflow;
    logic out_c;
    logic zero;
  } flags_t;

  localparam int FLAG_W  = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 0;

  localparam int CNT_W = 8;

endpackage

// File: rtl/res_fifo.sv
// Result FIFO: first-word fall-through storage with power-of-two depth and wrapping pointers.
module res_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_res_buf.sv
// Buffers adder results with their flags, tracks a sticky zero-flag consistency error.
// Define ALU_RES_BUF_STATS_EN to add saturating overflow/carry push counters (of_cnt, c_cnt).
module alu_res_buf
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] s,
  input  logic              overflow,
  input  logic              zero,
  input  logic              out_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic [FLAG_W-1:0] out_flags,
  input  logic              clr,
`ifdef ALU_RES_BUF_STATS_EN
  output logic [CNT_W-1:0]  of_cnt,
  output logic [CNT_W-1:0]  c_cnt,
`endif
  output logic              flag_err
);

  localparam int ENTRY_W = DATA_W + FLAG_W;

  flags_t             in_flags;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push_fire;
  logic               zero_bad;

  assign in_flags  = '{overflow: overflow, out_c: out_c, zero: zero};
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push_fire = in_valid && !full;
  assign zero_bad  = push_fire && (zero != (s == '0));

  res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (out_ready),
    .wdata ({s, in_flags}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_s     = head[ENTRY_W-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];

  // A new inconsistency in the same cycle as clr must still be reported.
  always_ff @(posedge clk) begin
    if (rst)           flag_err <= 1'b0;
    else if (zero_bad) flag_err <= 1'b1;
    else if (clr)      flag_err <= 1'b0;
  end

`ifdef ALU_RES_BUF_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      of_cnt <= '0;
      c_cnt  <= '0;
    end else begin
      if (push_fire && in_flags.overflow && of_cnt != CNT_MAX) of_cnt <= of_cnt + CNT_W'(1);
      if (push_fire && in_flags.out_c && c_cnt != CNT_MAX)     c_cnt  <= c_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_res_buf.sv
// Self-checking bench for alu_res_buf: directed scenarios plus randomized traffic against a queue model.
module tb_alu_res_buf;

  localparam int DW  = 4;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] s;
  logic          overflow;
  logic          zero;
  logic          out_c;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_s;
  logic [2:0]    out_flags;
  logic          clr;
  logic          flag_err;
`ifdef ALU_RES_BUF_STATS_EN
  logic [7:0]    of_cnt;
  logic [7:0]    c_cnt;
`endif

  alu_res_buf #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .overflow  (overflow),
    .zero      (zero),
    .out_c     (out_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_flags (out_flags),
    .clr       (clr),
`ifdef ALU_RES_BUF_STATS_EN
    .of_cnt    (of_cnt),
    .c_cnt     (c_cnt),
`endif
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference state: entries as {s, overflow, out_c, zero}
  logic [DW+2:0] q[$];
  logic          m_ferr = 1'b0;
  int            m_of = 0;
  int            m_c  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [DW+2:0] hd;
    hd = (q.size() != 0) ? q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEP));
    chk("out_s",     32'(out_s),     32'(hd[DW+2:3]));
    chk("out_flags", 32'(out_flags), 32'(hd[2:0]));
    chk("flag_err",  32'(flag_err),  32'(m_ferr));
`ifdef ALU_RES_BUF_STATS_EN
    chk("of_cnt", 32'(of_cnt), 32'(m_of));
    chk("c_cnt",  32'(c_cnt),  32'(m_c));
`endif
  endtask

  // One clock: predict from pre-edge model state and inputs, then compare just after the edge.
  task automatic tick();
    bit do_push, do_pop, bad;
    do_push = in_valid && (q.size() < DEP);
    do_pop  = out_ready && (q.size() > 0);
    bad     = do_push && (zero != (s == 0));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ferr = 1'b0;
      m_of = 0;
      m_c  = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({s, overflow, out_c, zero});
      if (bad) m_ferr = 1'b1;
      else if (clr) m_ferr = 1'b0;
      if (clr) begin
        m_of = 0;
        m_c  = 0;
      end else if (do_push) begin
        if (overflow && m_of < 255) m_of++;
        if (out_c && m_c < 255) m_c++;
      end
    end
    #1;
    check_model();
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] sv, input bit of, input bit c,
                       input bit z, input bit ordy, input bit cl);
    in_valid = v; s = sv; overflow = of; out_c = c; zero = z; out_ready = ordy; clr = cl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, 0, 0);
  endtask

  logic [3:0] exp_s [4];
  logic [2:0] exp_f [4];

  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    // single push, one-cycle latency
    drive(1, 4'h5, 0, 0, 0, 0, 0); tick();
    chk("first_out_s",     32'(out_s),     32'h5);
    chk("first_out_flags", 32'(out_flags), 32'b000);
    chk("first_valid",     32'(out_valid), 32'd1);
    idle(); out_ready = 1'b1; tick();
    idle(); tick();

    // fill to full, then a fifth push that must be dropped
    drive(1, 4'h8, 1, 0, 0, 0, 0); tick();
    drive(1, 4'h0, 1, 1, 1, 0, 0); tick();
    drive(1, 4'h3, 0, 0, 0, 0, 0); tick();
    drive(1, 4'h2, 0, 0, 0, 0, 0); tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 4'h9, 0, 0, 0, 0, 0); tick();
    exp_s = '{4'h8, 4'h0, 4'h3, 4'h2};
    exp_f = '{3'b100, 3'b111, 3'b000, 3'b000};
    for (int i = 0; i < 4; i++) begin
      chk("drain_s",     32'(out_s),     32'(exp_s[i]));
      chk("drain_flags", 32'(out_flags), 32'(exp_f[i]));
      idle(); out_ready = 1'b1; tick();
    end
    chk("drained_empty", 32'(out_valid), 32'd0);

    // full with push and pop together: only the pop happens
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i + 1), 0, 0, 0, 0, 0); tick();
    end
    drive(1, 4'hF, 0, 0, 0, 1, 0); tick();
    chk("full_both_ready", 32'(in_ready), 32'd1);
    chk("full_both_head",  32'(out_s),    32'h2);

    // drain to two entries, then stream through with pointer wrap
    idle(); out_ready = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'(i + 6), 0, 0, 0, 1, 0); tick();
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    idle(); out_ready = 1'b1; tick(); tick(); tick();

    // sticky zero-flag error, clear, and set-wins
    drive(1, 4'h0, 0, 0, 0, 1, 0); tick();
    chk("ferr_set", 32'(flag_err), 32'd1);
    drive(0, 4'h0, 0, 0, 0, 1, 1); tick();
    chk("ferr_clr", 32'(flag_err), 32'd0);
    drive(1, 4'h4, 0, 0, 1, 1, 1); tick();
    chk("ferr_set_wins", 32'(flag_err), 32'd1);
    drive(0, 4'h0, 0, 0, 0, 1, 1); tick();

    // randomized traffic with occasional clr and rst
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rs;
      int ready_pct;
      rs = 4'($urandom_range(0, 15));
      ready_pct = (i / 100) % 2 == 0 ? 30 : 80;
      in_valid  = $urandom_range(0, 99) < 70;
      s         = rs;
      overflow  = $urandom_range(0, 1);
      out_c     = $urandom_range(0, 1);
      zero      = ($urandom_range(0, 15) == 0) ? (rs != 0) : (rs == 0);
      out_ready = $urandom_range(0, 99) < ready_pct;
      clr       = $urandom_range(0, 29) == 0;
      rst       = $urandom_range(0, 149) == 0;
      tick();
    end
    rst = 1'b0;
    idle(); tick();

`ifdef ALU_RES_BUF_STATS_EN
    drive(0, 0, 0, 0, 1, 0, 1); tick();
    for (int i = 0; i < 300; i++) begin
      drive(1, 4'h1, 1, 0, 0, 1, 0); tick();
    end
    chk("of_cnt_sat", 32'(of_cnt), 32'd255);
`endif

    // reset mid-stream overrides push, pop and clr
    drive(1, 4'h0, 0, 0, 0, 0, 0); tick();
    drive(1, 4'h7, 1, 1, 0, 0, 0); tick();
    drive(1, 4'h0, 1, 1, 0, 1, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_flag_err",  32'(flag_err),  32'd0);
    chk("rst_out_s",     32'(out_s),     32'd0);
`ifdef ALU_RES_BUF_STATS_EN
    chk("rst_of_cnt", 32'(of_cnt), 32'd0);
`endif
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
